// File: rtl/axi_tcm_region_router.sv
// AXI4-lite slave that forwards one transaction at a time to a TCM region or,
// on a decode miss, to a default slave (or answers DECERR), with a wait timeout.
module axi_tcm_region_router #(
  parameter int NUM_REGIONS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_SIZE = {32'h0001_0000, 32'h0001_0000},
  parameter int DEFAULT_EN     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              AWVALID,
  output logic                              AWREADY,
  input  logic [ADDR_WIDTH-1:0]             AWADDR,
  input  logic [2:0]                        AWPROT,
  input  logic                              WVALID,
  output logic                              WREADY,
  input  logic [DATA_WIDTH-1:0]             WDATA,
  input  logic [DATA_WIDTH/8-1:0]           WSTRB,
  output logic                              BVALID,
  input  logic                              BREADY,
  output logic [1:0]                        BRESP,
  input  logic                              ARVALID,
  output logic                              ARREADY,
  input  logic [ADDR_WIDTH-1:0]             ARADDR,
  input  logic [2:0]                        ARPROT,
  output logic                              RVALID,
  input  logic                              RREADY,
  output logic [DATA_WIDTH-1:0]             RDATA,
  output logic [1:0]                        RRESP,
  input  logic [NUM_REGIONS-1:0]            region_lock,
  output logic [NUM_REGIONS-1:0]            tcm_req,
  output logic [ADDR_WIDTH-1:0]             tcm_addr,
  output logic                              tcm_rd0_wr1,
  output logic [DATA_WIDTH/8-1:0]           tcm_byte_strobe,
  output logic [DATA_WIDTH-1:0]             tcm_write_data,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] tcm_read_data,
  input  logic [NUM_REGIONS-1:0]            tcm_read_data_valid,
  output logic                              def_req,
  output logic                              def_rd0_wr1,
  input  logic                              def_ack,
  input  logic [DATA_WIDTH-1:0]             def_rdata,
  input  logic [1:0]                        def_resp
);

  typedef enum logic [2:0] {IDLE, TCM_ACC, TCM_WAIT, DEF_WAIT, B_RESP, R_RESP} state_t;

  state_t                  state, state_n;
  logic                    last_wr, is_wr;
  logic [NUM_REGIONS-1:0]  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [ADDR_WIDTH:0]     lo, hi;
  logic                    grant_wr, grant_rd, accept;
  logic [7:0]              wait_cnt;
  logic                    timeout;
  logic                    tcm_done;
  logic [DATA_WIDTH-1:0]   tcm_rdata_sel;
  logic [1:0]              resp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    unused_prot;

  // Protection bits carry no meaning for the TCMs.
  assign unused_prot = ^{AWPROT, ARPROT};

  // Alternate between kinds when both are pending; writes first after reset.
  assign grant_wr = (state == IDLE) && AWVALID && WVALID && (!ARVALID || !last_wr);
  assign grant_rd = (state == IDLE) && ARVALID && !grant_wr;
  assign accept   = grant_wr || grant_rd;
  assign acc_addr = grant_wr ? AWADDR : ARADDR;
  assign timeout  = (wait_cnt == 8'(TIMEOUT_CYCLES));

  // Region decode: lowest-index unlocked hit wins; one extra bit keeps base+size from wrapping.
  always_comb begin
    sel_d = '0;
    lo    = '0;
    hi    = '0;
    for (int i = NUM_REGIONS-1; i >= 0; i--) begin
      lo = {1'b0, REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]};
      hi = lo + {1'b0, REGION_SIZE[i*ADDR_WIDTH +: ADDR_WIDTH]};
      if (!region_lock[i] && ({1'b0, acc_addr} >= lo) && ({1'b0, acc_addr} < hi)) begin
        sel_d    = '0;
        sel_d[i] = 1'b1;
      end
    end
  end

  // Completion and read data of the region latched at accept time.
  always_comb begin
    tcm_done      = 1'b0;
    tcm_rdata_sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_q[i]) begin
        tcm_done      = tcm_read_data_valid[i];
        tcm_rdata_sel = tcm_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) begin
        if (|sel_d)               state_n = TCM_ACC;
        else if (DEFAULT_EN != 0) state_n = DEF_WAIT;
        else                      state_n = grant_wr ? B_RESP : R_RESP;
      end
      TCM_ACC:  state_n = is_wr ? B_RESP : TCM_WAIT;
      TCM_WAIT: if (tcm_done || timeout) state_n = R_RESP;
      DEF_WAIT: if (def_ack || timeout)  state_n = is_wr ? B_RESP : R_RESP;
      B_RESP:   if (BREADY) state_n = IDLE;
      R_RESP:   if (RREADY) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Handshake and request outputs decoded from state.
  always_comb begin
    AWREADY = grant_wr;
    WREADY  = grant_wr;
    ARREADY = grant_rd;
    BVALID  = (state == B_RESP);
    RVALID  = (state == R_RESP);
    def_req = (state == DEF_WAIT);
  end

  assign def_rd0_wr1 = tcm_rd0_wr1;
  assign BRESP       = resp_q;
  assign RRESP       = resp_q;
  assign RDATA       = rdata_q;

  // Request capture, downstream strobe, wait counter and response payload.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_wr         <= 1'b0;
      is_wr           <= 1'b0;
      sel_q           <= '0;
      tcm_req         <= '0;
      tcm_addr        <= '0;
      tcm_rd0_wr1     <= 1'b0;
      tcm_byte_strobe <= '0;
      tcm_write_data  <= '0;
      wait_cnt        <= '0;
      resp_q          <= 2'b00;
      rdata_q         <= '0;
    end else begin
      tcm_req  <= '0;
      wait_cnt <= (state == TCM_WAIT || state == DEF_WAIT) ? wait_cnt + 8'd1 : 8'd0;
      if (accept) begin
        last_wr         <= grant_wr;
        is_wr           <= grant_wr;
        sel_q           <= sel_d;
        tcm_addr        <= acc_addr;
        tcm_rd0_wr1     <= grant_wr;
        tcm_byte_strobe <= grant_wr ? WSTRB : '0;
        tcm_write_data  <= grant_wr ? WDATA : '0;
        if (|sel_d) tcm_req <= sel_d;
        else if (DEFAULT_EN == 0) begin
          resp_q  <= 2'b11;
          rdata_q <= '0;
        end
      end
      if (state == TCM_ACC && is_wr) resp_q <= 2'b00;
      if (state == TCM_WAIT) begin
        if (tcm_done) begin
          resp_q  <= 2'b00;
          rdata_q <= tcm_rdata_sel;
        end else if (timeout) begin
          resp_q  <= 2'b10;
          rdata_q <= '0;
        end
      end
      if (state == DEF_WAIT) begin
        if (def_ack) begin
          resp_q  <= def_resp;
          rdata_q <= is_wr ? '0 : def_rdata;
        end else if (timeout) begin
          resp_q  <= 2'b10;
          rdata_q <= '0;
        end
      end
    end
  end

endmodule
